async_fifo_rd_stream: RTL and testbench

//  Read-side consumer for async_fifo, running in the rd_clk domain. Drives the FIFO read port:
//  rd_en, rdata returned one edge after the read, combinational empty. Re-times the data into
//  a valid/ready stream with BURST_LEN framing (out_last), a beat counter and a sticky underflow error.

---
 rtl/async_fifo_rd_pkg.sv | 21 ++
 rtl/async_fifo_rd_stream_skid.sv | 59 +++++
 rtl/async_fifo_rd_stream.sv | 113 +++++++++++
 tb/tb_async_fifo_rd_stream.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_rd_pkg.sv
// ============================================================================
//  Module   : async_fifo_rd_pkg
//  Brief    : Shared types and constants for the async FIFO read-side streamer
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/async_fifo_rd_stream_skid.sv
// ============================================================================
//  Module   : rd_skid_buf
//  Brief    : Two-entry register FIFO absorbing the one-cycle FIFO read latency
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_skid_buf
  import async_fifo_rd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;

  // entry0 is always the head; a pop shifts entry1 forward
  always_ff @(posedge clk) begin
    if (res) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) entry0 <= din;
          else             entry1 <= din;
          count <= count + SKID_CNT_W'(1);
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - SKID_CNT_W'(1);
        end
        2'b11: begin
          if (count == SKID_CNT_W'(1)) begin
            entry0 <= din;
          end else begin
            entry0 <= entry1;
            entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = entry0;

endmodule

`default_nettype wire

// File: rtl/async_fifo_rd_stream.sv
// ============================================================================
//  Module   : async_fifo_rd_stream
//  Brief    : FIFO read-port driver re-timing data into a framed valid/ready stream
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_rd_stream
  import async_fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 res,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic                 fifo_underflow,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_rd_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 err_underflow
);

  localparam int                BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  rd_state_t             state;
  rd_state_t             state_next;
  logic                  fetching;
  logic                  inflight;
  logic                  pop;
  logic [SKID_CNT_W-1:0] count;
  logic [WIDTH-1:0]      head;
  logic [2:0]            occupancy;
  logic [BEAT_W-1:0]     beat_cnt;

  always_ff @(posedge rd_clk) begin
    if (res) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = FETCH;
      FETCH:   if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable)                                 state_next = FETCH;
        else if ((count == '0) && !inflight)        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetching = 1'b0;
    busy     = 1'b0;
    if (!res) begin
      fetching = (state == FETCH);
      busy     = (state != IDLE);
    end
  end

  // Issue only when the word being read is guaranteed a skid slot after this edge's pop
  assign out_valid  = !res && (count != '0);
  assign pop        = out_valid && out_ready;
  assign occupancy  = 3'(count) + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = fetching && !fifo_empty && (occupancy <= 3'd1);
  assign out_data   = res ? '0 : head;
  assign out_last   = out_valid && (beat_cnt == LAST_BEAT);

  always_ff @(posedge rd_clk) begin
    if (res) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (rd_clk),
    .res   (res),
    .push  (inflight),
    .pop   (pop),
    .din   (fifo_rdata),
    .dout  (head),
    .count (count)
  );

  // Frame position survives enable toggling so a paused frame resumes in place
  always_ff @(posedge rd_clk) begin
    if (res) begin
      beat_cnt      <= '0;
      rd_count      <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (pop) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
      if (fifo_underflow) err_underflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_async_fifo_rd_stream.sv
// ============================================================================
//  Module   : tb_async_fifo_rd_stream
//  Brief    : Self-checking bench with a behavioural FIFO and stream scoreboard
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_fifo_rd_stream;

  localparam int WIDTH     = 8;
  localparam int BURST_LEN = 4;
  localparam int CNT_WIDTH = 16;

  logic                 rd_clk = 1'b0;
  logic                 res = 1'b1;
  logic                 enable = 1'b0;
  logic                 fifo_underflow = 1'b0;
  logic                 out_ready = 1'b0;
  logic [WIDTH-1:0]     fifo_rdata = '0;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic                 busy;
  logic [CNT_WIDTH-1:0] rd_count;
  logic                 err_underflow;

  always #5 rd_clk = ~rd_clk;

  async_fifo_rd_stream #(
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .rd_clk         (rd_clk),
    .res            (res),
    .enable         (enable),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_rdata     (fifo_rdata),
    .fifo_rd_en     (fifo_rd_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .rd_count       (rd_count),
    .err_underflow  (err_underflow)
  );

  // Behavioural source FIFO: combinational empty, data one edge after the read
  logic [WIDTH-1:0] fifo_mem [0:255];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (wp == rp);

  // Reference model: words handed out by the FIFO must emerge in order, once each
  logic [WIDTH-1:0] exp_q[$];
  int m_beat  = 0;
  int m_pops  = 0;
  int m_reads = 0;
  bit m_err   = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge rd_clk) begin
    if (res) begin
      exp_q.delete();
      m_beat  = 0;
      m_pops  = 0;
      m_reads = 0;
      m_err   = 1'b0;
      rp     <= wp;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_beat = (m_beat + 1) % BURST_LEN;
        m_pops++;
      end
      if (fifo_underflow) m_err = 1'b1;
      if (fifo_rd_en) begin
        exp_q.push_back(fifo_mem[rp % 256]);
        fifo_rdata <= fifo_mem[rp % 256];
        rp         <= rp + 1;
        m_reads++;
      end
    end
  end

  always @(negedge rd_clk) begin
    check_eq("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
    check_eq("rd_count", 32'(rd_count), 32'(m_pops % (1 << CNT_WIDTH)));
    check_eq("err_underflow", 32'(err_underflow), 32'(m_err));
    check_eq("outstanding_le_2", 32'((m_reads - m_pops) <= 2), 1);
    check_eq("out_last", 32'(out_last), 32'(out_valid && (m_beat == BURST_LEN - 1)));
    if (out_valid) begin
      check_eq("valid_with_data", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("out_data", 32'(out_data), 32'(exp_q[0]));
    end
  end

  task automatic step();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    fifo_mem[wp % 256] = d;
    wp = wp + 1;
  endtask

  task automatic wait_beat(input logic [WIDTH-1:0] d, input int max, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge rd_clk);
      if (out_valid && out_data == d) ok = 1'b1;
    end
    check_eq(tag, 32'(ok), 1);
  endtask

  initial begin
    int r0;
    int held;
    int pushes;

    // Reset with words sitting in the FIFO; the FIFO shares res and is cleared
    push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    @(negedge rd_clk);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 0);
    check_eq("rst_valid", 32'(out_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_count", 32'(rd_count), 0);
    check_eq("rst_data", 32'(out_data), 0);
    step();
    res = 1'b0;

    // Idle with words present and enable low
    push_word(8'h01); push_word(8'h02); push_word(8'h03);
    repeat (4) begin
      @(negedge rd_clk);
      check_eq("idle_rd_en", 32'(fifo_rd_en), 0);
      check_eq("idle_busy", 32'(busy), 0);
      check_eq("idle_valid", 32'(out_valid), 0);
    end

    // Streaming 0x01..0x08 at one beat per cycle
    step();
    for (int i = 4; i <= 8; i++) push_word(8'(i));
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_beat(8'h01, 20, "stream_start");
    for (int i = 1; i <= 8; i++) begin
      check_eq("stream_valid", 32'(out_valid), 1);
      check_eq("stream_seq", 32'(out_data), 32'(i));
      check_eq("stream_last", 32'(out_last), 32'((i % 4) == 0));
      @(negedge rd_clk);
    end
    check_eq("stream_count", 32'(rd_count), 8);
    step();
    enable = 1'b0;
    repeat (3) step();
    @(negedge rd_clk);
    check_eq("stream_idle", 32'(busy), 0);

    // Backpressure: downstream stalled while the FIFO holds data
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    enable = 1'b1;
    r0 = m_reads;
    wait_beat(8'h10, 20, "bp_first");
    held = int'(out_data);
    repeat (5) begin
      @(negedge rd_clk);
      check_eq("bp_hold_valid", 32'(out_valid), 1);
      check_eq("bp_hold_data", 32'(out_data), 32'(held));
    end
    check_eq("bp_max_reads", 32'((m_reads - r0) <= 2), 1);
    step();
    out_ready = 1'b1;
    wait_beat(8'h17, 30, "bp_release");
    check_eq("bp_last", 32'(out_last), 1);
    step(); step();
    @(negedge rd_clk);
    check_eq("bp_count", 32'(rd_count), 16);
    check_eq("bp_drained", 32'(out_valid), 0);

    // Empty boundary: a single word yields a single read
    step();
    r0 = m_reads;
    push_word(8'h20);
    repeat (8) step();
    check_eq("one_word_reads", 32'(m_reads - r0), 1);
    check_eq("one_word_count", 32'(rd_count), 17);
    check_eq("one_word_uf", 32'(err_underflow), 0);

    // Finish the open frame, then pause after two beats of the next one
    push_word(8'h21); push_word(8'h22); push_word(8'h23);
    wait_beat(8'h23, 20, "frame_close");
    check_eq("frame_close_last", 32'(out_last), 1);
    step();
    for (int i = 0; i < 8; i++) push_word(8'(8'h30 + i));
    wait_beat(8'h31, 20, "pause_beat2");
    step();
    enable = 1'b0;
    wait_beat(8'h33, 10, "pause_inflight");
    check_eq("pause_last_4th", 32'(out_last), 1);
    repeat (5) step();
    @(negedge rd_clk);
    check_eq("pause_idle", 32'(busy), 0);
    check_eq("pause_all_delivered", 32'(m_reads - m_pops), 0);
    step();
    enable = 1'b1;
    wait_beat(8'h37, 30, "resume_end");
    check_eq("resume_last", 32'(out_last), 1);

    // Underflow is sticky
    step();
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    repeat (3) begin
      @(negedge rd_clk);
      check_eq("uf_sticky", 32'(err_underflow), 1);
    end

    // Reset mid-stream
    step();
    for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
    wait_beat(8'h42, 20, "mid_stream");
    step();
    res = 1'b1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    check_eq("mrst_rd_en", 32'(fifo_rd_en), 0);
    check_eq("mrst_valid", 32'(out_valid), 0);
    check_eq("mrst_data", 32'(out_data), 0);
    check_eq("mrst_last", 32'(out_last), 0);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_count", 32'(rd_count), 0);
    check_eq("mrst_uf", 32'(err_underflow), 0);
    step();
    res = 1'b0;

    // Randomized traffic, backpressure and enable toggling
    pushes = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if (pushes < 60 && $urandom_range(0, 2) == 0) begin
        push_word(8'($urandom));
        pushes++;
      end
    end
    step();
    enable    = 1'b1;
    out_ready = 1'b1;
    repeat (20) step();
    @(negedge rd_clk);
    check_eq("rand_drained", 32'(out_valid), 0);
    check_eq("rand_all_delivered", 32'(m_reads - m_pops), 0);
    check_eq("rand_total", 32'(rd_count), 32'(pushes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
